// File: rtl/tetris_pkg.sv
// Shared types for the tetris command sequencer: engine command encoding,
// sequencer FSM states and the bit layout of the pending-command vector.
package tetris_pkg;

    // Command codes understood by the tetris engine
    typedef enum logic [1:0] {
        CMD_RIGHT  = 2'b00,
        CMD_DOWN   = 2'b01,
        CMD_LEFT   = 2'b10,
        CMD_ROTATE = 2'b11
    } ctrl_cmd_e;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        GAP,
        PAUSE
    } state_e;

    // Button vector layout (registered copy and rise detect share it)
    localparam int NUM_BTN = 6;
    localparam int B_START = 0;
    localparam int B_PAUSE = 1;
    localparam int B_ROT   = 2;
    localparam int B_LEFT  = 3;
    localparam int B_RIGHT = 4;
    localparam int B_DOWN  = 5;

    // Pending-command vector layout
    localparam int NUM_PEND = 5;
    localparam int P_ROT    = 0;
    localparam int P_LEFT   = 1;
    localparam int P_RIGHT  = 2;
    localparam int P_UDOWN  = 3;
    localparam int P_GRAV   = 4;

    // Gap counter width; CMD_GAP is limited to 16 bits
    localparam int GAP_W = 16;

    // States in which gameplay time advances (gravity runs, presses latch)
    function automatic logic in_play(state_e s);
        return (s == RUN) || (s == GAP);
    endfunction

endpackage

// File: rtl/tetris_gravity_timer.sv
// Gravity timer: counts enabled cycles and raises tick for one cycle every
// max(1, GRAVITY_BASE >> level) enabled cycles. Holding en low freezes the
// count (pause); clr forces it back to zero.
module tetris_gravity_timer
#(
    parameter int GRAVITY_BASE = 25000000,
    parameter int LEVEL_W      = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               clr,
    input  logic [LEVEL_W-1:0] level,
    output logic               tick
);

    localparam int CNT_W = (GRAVITY_BASE > 1) ? $clog2(GRAVITY_BASE + 1) : 1;
    localparam logic [CNT_W-1:0] BASE = CNT_W'(GRAVITY_BASE);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_raw;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] last;

    // Level-scaled period, never below one cycle
    always_comb begin
        period_raw = BASE >> level;
        period     = (period_raw == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : period_raw;
        last       = period - 1'b1;
    end

    // >= rather than == so a level change that shrinks the period below the
    // current count still produces a tick on the next enabled edge
    assign tick = en && (cnt >= last);

    // Period counter: wraps to zero on the tick edge, frozen while disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tetris_ctrl.sv
// Command sequencer in front of the tetris engine. Converts button rises
// and gravity ticks into one-cycle ctrl_valid/ctrl strobes, spaces strobes
// at least CMD_GAP cycles apart so the engine's multi-cycle sequences
// always complete, and sequences start, restart after game over, and pause.
module tetris_ctrl
    import tetris_pkg::*;
#(
    parameter int CMD_GAP      = 256,
    parameter int GRAVITY_BASE = 25000000,
    parameter int LEVEL_W      = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               btn_rotate,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_down,
    input  logic [LEVEL_W-1:0] level,
    input  logic               game_over,
    output logic               ctrl_valid,
    output logic [1:0]         ctrl,
    output logic               running,
    output logic               paused
);

    // Gap counter load: the issue edge itself plus the terminal-count edge
    // and the RUN edge account for the remaining cycles of CMD_GAP
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CMD_GAP - 2);

    state_e               state;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 restart;

    logic [NUM_BTN-1:0]   btn;
    logic [NUM_BTN-1:0]   btn_q;
    logic [NUM_BTN-1:0]   rise;

    logic [NUM_PEND-1:0]  pend;
    logic [NUM_PEND-1:0]  pend_set;
    logic [NUM_PEND-1:0]  pend_clr;
    logic [NUM_PEND-1:0]  issue_mask;
    ctrl_cmd_e            issue_cmd;
    logic                 issue;

    logic                 play;
    logic                 grav_clr;
    logic                 grav_tick;

    assign btn = {btn_down, btn_right, btn_left, btn_rotate, btn_pause, btn_start};

    // Previous button sample for rise detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

    assign play     = in_play(state);
    assign grav_clr = (state == IDLE) || (state == START);

    tetris_gravity_timer #(
        .GRAVITY_BASE (GRAVITY_BASE),
        .LEVEL_W      (LEVEL_W)
    ) u_grav (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (play),
        .clr     (grav_clr),
        .level   (level),
        .tick    (grav_tick)
    );

    // Fixed-priority pick among pending commands; a down issue retires both
    // the gravity and the user-down request since they mean the same move
    always_comb begin
        issue_cmd  = CMD_RIGHT;
        issue_mask = '0;
        if (pend[P_GRAV]) begin
            issue_cmd           = CMD_DOWN;
            issue_mask[P_GRAV]  = 1'b1;
            issue_mask[P_UDOWN] = 1'b1;
        end else if (pend[P_ROT]) begin
            issue_cmd          = CMD_ROTATE;
            issue_mask[P_ROT]  = 1'b1;
        end else if (pend[P_LEFT]) begin
            issue_cmd          = CMD_LEFT;
            issue_mask[P_LEFT] = 1'b1;
        end else if (pend[P_RIGHT]) begin
            issue_cmd           = CMD_RIGHT;
            issue_mask[P_RIGHT] = 1'b1;
        end else if (pend[P_UDOWN]) begin
            issue_cmd           = CMD_DOWN;
            issue_mask[P_GRAV]  = 1'b1;
            issue_mask[P_UDOWN] = 1'b1;
        end
    end

    // Issue only from RUN; game over and a pause press both take precedence
    assign issue = (state == RUN) && !game_over && !rise[B_PAUSE] && (pend != '0);

    // Set and clear masks for the pending vector
    always_comb begin
        pend_set         = '0;
        pend_set[P_ROT]   = rise[B_ROT];
        pend_set[P_LEFT]  = rise[B_LEFT];
        pend_set[P_RIGHT] = rise[B_RIGHT];
        pend_set[P_UDOWN] = rise[B_DOWN];
        pend_set[P_GRAV]  = grav_tick;
        if (!play) begin
            pend_set = '0;
        end
        pend_clr = issue ? issue_mask : '0;
    end

    // Pending requests: one bit each, repeats collapse; a fresh rise on the
    // issue edge survives the clear so that press is not lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else if (grav_clr) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
        end
    end

    // Sequencer FSM with registered strobe and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            restart    <= 1'b0;
            ctrl_valid <= 1'b0;
            ctrl       <= CMD_RIGHT;
            running    <= 1'b0;
            paused     <= 1'b0;
        end else begin
            ctrl_valid <= 1'b0;
            case (state)
                IDLE: begin
                    running <= 1'b0;
                    paused  <= 1'b0;
                    if (rise[B_START]) begin
                        state <= START;
                    end
                end
                START: begin
                    // A down command takes the engine out of INIT or END
                    ctrl_valid <= 1'b1;
                    ctrl       <= CMD_DOWN;
                    gap_cnt    <= GAP_LOAD;
                    state      <= GAP;
                    running    <= 1'b1;
                end
                RUN: begin
                    if (game_over) begin
                        state   <= IDLE;
                        restart <= 1'b1;
                        running <= 1'b0;
                        paused  <= 1'b0;
                    end else if (rise[B_PAUSE]) begin
                        state  <= PAUSE;
                        paused <= 1'b1;
                    end else if (issue) begin
                        ctrl_valid <= 1'b1;
                        ctrl       <= issue_cmd;
                        gap_cnt    <= GAP_LOAD;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (game_over) begin
                        state   <= IDLE;
                        restart <= 1'b1;
                        running <= 1'b0;
                        paused  <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        // After a game over the engine needs a second down
                        // (END->INIT, then INIT->NEXT) before play resumes
                        if (restart) begin
                            restart <= 1'b0;
                            state   <= START;
                            running <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                PAUSE: begin
                    if (game_over) begin
                        state   <= IDLE;
                        restart <= 1'b1;
                        running <= 1'b0;
                        paused  <= 1'b0;
                    end else if (rise[B_PAUSE]) begin
                        state  <= RUN;
                        paused <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    paused  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_ctrl.sv
// Bench for tetris_ctrl: expected strobes (cycle, code) are queued when
// stimulus is driven; a monitor logs every ctrl_valid cycle and each test
// drains the queue against the log, flagging missing and extra strobes.
module tb_tetris_ctrl;

    localparam int G    = 16;
    localparam int BASE = 1000;
    localparam int LW   = 3;

    localparam logic [5:0] K_START = 6'b000001;
    localparam logic [5:0] K_PAUSE = 6'b000010;
    localparam logic [5:0] K_ROT   = 6'b000100;
    localparam logic [5:0] K_LEFT  = 6'b001000;
    localparam logic [5:0] K_RIGHT = 6'b010000;
    localparam logic [5:0] K_DOWN  = 6'b100000;

    typedef struct packed {
        int         cyc;
        logic [1:0] cmd;
    } strobe_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [5:0]    btn = '0;
    logic [LW-1:0] level = '0;
    logic          game_over = 1'b0;
    logic          ctrl_valid;
    logic [1:0]    ctrl;
    logic          running;
    logic          paused;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         rd = 0;
    int         obs_n = 0;
    int         obs_cyc [64];
    logic [1:0] obs_cmd [64];
    strobe_t    exp_q [$];
    int         start_cyc = 0;

    tetris_ctrl #(
        .CMD_GAP      (G),
        .GRAVITY_BASE (BASE),
        .LEVEL_W      (LW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_start  (btn[0]),
        .btn_pause  (btn[1]),
        .btn_rotate (btn[2]),
        .btn_left   (btn[3]),
        .btn_right  (btn[4]),
        .btn_down   (btn[5]),
        .level      (level),
        .game_over  (game_over),
        .ctrl_valid (ctrl_valid),
        .ctrl       (ctrl),
        .running    (running),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log, sampled mid-cycle
    always @(negedge clk) begin
        if (ctrl_valid === 1'b1 && obs_n < 64) begin
            obs_cyc[obs_n] <= cyc;
            obs_cmd[obs_n] <= ctrl;
            obs_n          <= obs_n + 1;
        end
    end

    // One press: high for one sample, then low for one sample
    task automatic pulse(input logic [5:0] m, output int n);
        btn = m;
        n   = cyc;
        @(negedge clk);
        btn = '0;
        @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ctrl_valid); end
        checks++;
        if (ctrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b want 00", ctrl); end
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        checks++;
        if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %b want 0", paused); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start();
        int n;
        strobe_t e;
        pulse(K_START, n);
        exp_q.push_back(strobe_t'{n + 2, 2'b01});
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %b want 1", running); end
        wait_until(n + 3 * G);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL start_run: got %b want 1", running); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++; $display("FAIL start_strobe: got none want cyc=%0d ctrl=%b", e.cyc, e.cmd);
            end else begin
                if (obs_cyc[rd] !== e.cyc || obs_cmd[rd] !== e.cmd) begin
                    errors++; $display("FAIL start_strobe: got cyc=%0d ctrl=%b want cyc=%0d ctrl=%b", obs_cyc[rd], obs_cmd[rd], e.cyc, e.cmd);
                end
                rd++;
            end
        end
        checks++;
        if (rd != obs_n) begin errors++; $display("FAIL start_extra: got %0d extra strobes want 0", obs_n - rd); rd = obs_n; end
    endtask

    task automatic test_simultaneous();
        int n;
        strobe_t e;
        pulse(K_ROT | K_LEFT, n);
        exp_q.push_back(strobe_t'{n + 2, 2'b11});
        exp_q.push_back(strobe_t'{n + 2 + G, 2'b10});
        wait_until(n + 2 + 3 * G);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++; $display("FAIL simul_strobe: got none want cyc=%0d ctrl=%b", e.cyc, e.cmd);
            end else begin
                if (obs_cyc[rd] !== e.cyc || obs_cmd[rd] !== e.cmd) begin
                    errors++; $display("FAIL simul_strobe: got cyc=%0d ctrl=%b want cyc=%0d ctrl=%b", obs_cyc[rd], obs_cmd[rd], e.cyc, e.cmd);
                end
                rd++;
            end
        end
        checks++;
        if (rd != obs_n) begin errors++; $display("FAIL simul_extra: got %0d extra strobes want 0", obs_n - rd); rd = obs_n; end
    endtask

    task automatic test_down_collapse();
        int n;
        int d;
        strobe_t e;
        pulse(K_RIGHT, n);
        exp_q.push_back(strobe_t'{n + 2, 2'b00});
        for (int i = 0; i < 5; i++) pulse(K_DOWN, d);
        exp_q.push_back(strobe_t'{n + 2 + G, 2'b01});
        wait_until(n + 2 + 3 * G);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++; $display("FAIL down_strobe: got none want cyc=%0d ctrl=%b", e.cyc, e.cmd);
            end else begin
                if (obs_cyc[rd] !== e.cyc || obs_cmd[rd] !== e.cmd) begin
                    errors++; $display("FAIL down_strobe: got cyc=%0d ctrl=%b want cyc=%0d ctrl=%b", obs_cyc[rd], obs_cmd[rd], e.cyc, e.cmd);
                end
                rd++;
            end
        end
        checks++;
        if (rd != obs_n) begin errors++; $display("FAIL down_extra: got %0d extra strobes want 0", obs_n - rd); rd = obs_n; end
    endtask

    task automatic test_game_over();
        int n;
        int m;
        strobe_t e;
        pulse(K_ROT, n);
        exp_q.push_back(strobe_t'{n + 2, 2'b11});
        game_over = 1'b1;
        @(negedge clk);
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL gameover_running: got %b want 0", running); end
        game_over = 1'b0;
        level     = 3'd2;
        repeat (3) @(negedge clk);
        pulse(K_START, m);
        start_cyc = m;
        exp_q.push_back(strobe_t'{m + 2, 2'b01});
        exp_q.push_back(strobe_t'{m + 2 + G, 2'b01});
        wait_until(m + 2 + G + 5);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL restart_running: got %b want 1", running); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++; $display("FAIL restart_strobe: got none want cyc=%0d ctrl=%b", e.cyc, e.cmd);
            end else begin
                if (obs_cyc[rd] !== e.cyc || obs_cmd[rd] !== e.cmd) begin
                    errors++; $display("FAIL restart_strobe: got cyc=%0d ctrl=%b want cyc=%0d ctrl=%b", obs_cyc[rd], obs_cmd[rd], e.cyc, e.cmd);
                end
                rd++;
            end
        end
        checks++;
        if (rd != obs_n) begin errors++; $display("FAIL restart_extra: got %0d extra strobes want 0", obs_n - rd); rd = obs_n; end
    endtask

    task automatic test_gravity_pause();
        localparam int P = BASE >> 2;
        int g1;
        int g2;
        int n;
        int mu;
        int c;
        int gp;
        int n2;
        int d;
        strobe_t e;
        // Counter cleared when the second START is entered (start+1+G)
        g1 = start_cyc + 1 + G + P + 2;
        g2 = g1 + P;
        exp_q.push_back(strobe_t'{g1, 2'b01});
        exp_q.push_back(strobe_t'{g2, 2'b01});
        wait_until(g2 + G + 5);
        pulse(K_PAUSE, n);
        c = n + 2 - g2;
        checks++;
        if (paused !== 1'b1) begin errors++; $display("FAIL pause_on: got %b want 1", paused); end
        wait_until(n + 600);
        pulse(K_PAUSE, mu);
        checks++;
        if (paused !== 1'b0) begin errors++; $display("FAIL pause_off: got %b want 0", paused); end
        gp = mu + 2 + P - c;
        exp_q.push_back(strobe_t'{gp, 2'b01});
        // Rotate opens a gap that spans the next gravity tick; a down press
        // lands in the same gap, so both retire with one down strobe
        wait_until(gp + P - 12);
        pulse(K_ROT, n2);
        exp_q.push_back(strobe_t'{n2 + 2, 2'b11});
        pulse(K_DOWN, d);
        exp_q.push_back(strobe_t'{n2 + 2 + G, 2'b01});
        wait_until(n2 + 2 + G + 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++; $display("FAIL grav_strobe: got none want cyc=%0d ctrl=%b", e.cyc, e.cmd);
            end else begin
                if (obs_cyc[rd] !== e.cyc || obs_cmd[rd] !== e.cmd) begin
                    errors++; $display("FAIL grav_strobe: got cyc=%0d ctrl=%b want cyc=%0d ctrl=%b", obs_cyc[rd], obs_cmd[rd], e.cyc, e.cmd);
                end
                rd++;
            end
        end
        checks++;
        if (rd != obs_n) begin errors++; $display("FAIL grav_extra: got %0d extra strobes want 0", obs_n - rd); rd = obs_n; end
    endtask

    task automatic test_async_reset();
        int n;
        int m;
        strobe_t e;
        pulse(K_ROT, n);
        exp_q.push_back(strobe_t'{n + 2, 2'b11});
        checks++;
        if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b want 1", ctrl_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", ctrl_valid); end
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL areset_running: got %b want 0", running); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse(K_START, m);
        exp_q.push_back(strobe_t'{m + 2, 2'b01});
        wait_until(m + 2 + 2 * G);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++; $display("FAIL areset_strobe: got none want cyc=%0d ctrl=%b", e.cyc, e.cmd);
            end else begin
                if (obs_cyc[rd] !== e.cyc || obs_cmd[rd] !== e.cmd) begin
                    errors++; $display("FAIL areset_strobe: got cyc=%0d ctrl=%b want cyc=%0d ctrl=%b", obs_cyc[rd], obs_cmd[rd], e.cyc, e.cmd);
                end
                rd++;
            end
        end
        checks++;
        if (rd != obs_n) begin errors++; $display("FAIL areset_extra: got %0d extra strobes want 0", obs_n - rd); rd = obs_n; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_start();
        test_simultaneous();
        test_down_collapse();
        test_game_over();
        test_gravity_pause();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
